// File: rtl/e_mdu_if.sv
// e_mdu_if: E-stage multiply/divide unit bundle.
//   master (pipeline side): drives Req, E_MDUop, E_A, E_B and observes E_Start, E_Busy, E_MUresult.
//   slave  (e_mdu side):    receives Req, E_MDUop, E_A, E_B and drives E_Start, E_Busy, E_MUresult.
interface e_mdu_if;
   logic        Req;
   logic [3:0]  E_MDUop;
   logic [31:0] E_A;
   logic [31:0] E_B;
   logic        E_Start;
   logic        E_Busy;
   logic [31:0] E_MUresult;
   modport master (output Req, E_MDUop, E_A, E_B, input E_Start, E_Busy, E_MUresult);
   modport slave  (input Req, E_MDUop, E_A, E_B, output E_Start, E_Busy, E_MUresult);
endinterface

// File: rtl/e_mdu.sv
// e_mdu: execute-stage multiply/divide unit owning HI/LO, multi-cycle behind a Start/Busy handshake.
//   clk   in  clock, all state on posedge
//   reset in  synchronous active-high reset
//   bus   slave modport of e_mdu_if: Req, E_MDUop, E_A, E_B in; E_Start, E_Busy, E_MUresult out
//   Optional macro MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU (ops 9-12) with an accumulator.
module e_mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input logic clk,
   input logic reset,
   e_mdu_if.slave bus
);
   localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW = $clog2(MAXC + 1);
   localparam logic [CW-1:0] N_MUL = CW'(MULT_CYCLES);
   localparam logic [CW-1:0] N_DIV = CW'(DIV_CYCLES);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t state;
   logic [CW-1:0] cnt;
   logic [31:0] hi, lo, p_hi, p_lo;
   logic p_wr;
   logic is_md, is_div, sgn, div_ovf, n_wr;
   logic [63:0] ea, eb, prod, n_res;
   logic [31:0] bs, bu, q_s, r_s, q_u, r_u;
   always_comb begin
      is_div = bus.E_MDUop == 4'd3 || bus.E_MDUop == 4'd4;
`ifdef MDU_MADD_EN
      is_md = bus.E_MDUop inside {[4'd1:4'd4], [4'd9:4'd12]};
`else
      is_md = bus.E_MDUop inside {[4'd1:4'd4]};
`endif
      sgn = bus.E_MDUop inside {4'd1, 4'd3, 4'd9, 4'd11};
      // One 64x64 multiply over sign- or zero-extended operands serves both signednesses.
      ea = {{32{sgn & bus.E_A[31]}}, bus.E_A};
      eb = {{32{sgn & bus.E_B[31]}}, bus.E_B};
      prod = ea * eb;
      // Divisors are steered away from 0 and from the INT_MIN/-1 overflow so the
      // divider never sees an undefined case; those results are patched or suppressed.
      div_ovf = bus.E_A == 32'h8000_0000 && bus.E_B == 32'hFFFF_FFFF;
      bs = (bus.E_B == 32'd0 || div_ovf) ? 32'd1 : bus.E_B;
      bu = bus.E_B == 32'd0 ? 32'd1 : bus.E_B;
      q_s = div_ovf ? bus.E_A : 32'($signed(bus.E_A) / $signed(bs));
      r_s = div_ovf ? 32'd0 : 32'($signed(bus.E_A) % $signed(bs));
      q_u = bus.E_A / bu;
      r_u = bus.E_A % bu;
`ifdef MDU_MADD_EN
      n_res = bus.E_MDUop == 4'd3 ? {r_s, q_s} :
              bus.E_MDUop == 4'd4 ? {r_u, q_u} :
              bus.E_MDUop inside {4'd9, 4'd10} ? {hi, lo} + prod :
              bus.E_MDUop inside {4'd11, 4'd12} ? {hi, lo} - prod : prod;
`else
      n_res = bus.E_MDUop == 4'd3 ? {r_s, q_s} :
              bus.E_MDUop == 4'd4 ? {r_u, q_u} : prod;
`endif
      n_wr = !is_div || bus.E_B != 32'd0;
   end
   assign bus.E_Start = is_md && state == IDLE && !bus.Req;
   assign bus.E_Busy = state == BUSY;
   assign bus.E_MUresult = bus.E_MDUop == 4'd5 ? hi : bus.E_MDUop == 4'd6 ? lo : 32'd0;
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt <= '0;
         hi <= '0;
         lo <= '0;
         p_hi <= '0;
         p_lo <= '0;
         p_wr <= 1'b0;
      end else if (state == IDLE) begin
         if (bus.E_Start) begin
            {p_hi, p_lo} <= n_res;
            p_wr <= n_wr;
            cnt <= is_div ? N_DIV : N_MUL;
            state <= BUSY;
         end else if (!bus.Req && bus.E_MDUop == 4'd7) begin
            hi <= bus.E_A;
         end else if (!bus.Req && bus.E_MDUop == 4'd8) begin
            lo <= bus.E_A;
         end
      end else begin
         cnt <= cnt - 1'b1;
         if (cnt == CW'(1)) begin
            state <= IDLE;
            if (p_wr) begin
               hi <= p_hi;
               lo <= p_lo;
            end
         end
      end
   end
endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: randomized and directed self-checking bench for e_mdu against an arithmetic HI/LO model.
//   Drives the master side of e_mdu_if; honours MDU_MADD_EN to match the DUT build.
module tb_e_mdu;
   localparam int MULT_N = 5;
   localparam int DIV_N = 10;
`ifdef MDU_MADD_EN
   localparam bit MADD = 1'b1;
`else
   localparam bit MADD = 1'b0;
`endif
   logic clk = 1'b0;
   logic reset = 1'b1;
   int n_chk = 0;
   int n_err = 0;
   logic [31:0] m_hi = '0, m_lo = '0;
   e_mdu_if bus();
   e_mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   function automatic bit starts(input logic [3:0] op);
      return op inside {[4'd1:4'd4]} || (MADD && op inside {[4'd9:4'd12]});
   endfunction
   task automatic model_calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             output logic [63:0] res, output bit wr);
      longint sa, sb, q, r;
      longint unsigned ua, ub, acc;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      acc = {m_hi, m_lo};
      res = '0;
      wr = 1'b1;
      case (op)
         4'd1: res = sa * sb;
         4'd2: res = ua * ub;
         4'd3: if (b == 0) wr = 1'b0; else begin q = sa / sb; r = sa % sb; res = {r[31:0], q[31:0]}; end
         4'd4: if (b == 0) wr = 1'b0; else res = {a % b, a / b};
         4'd9: res = acc + sa * sb;
         4'd10: res = acc + ua * ub;
         4'd11: res = acc - sa * sb;
         4'd12: res = acc - ua * ub;
         default: wr = 1'b0;
      endcase
   endtask
   task automatic read_hl(output logic [31:0] h, output logic [31:0] l);
      @(negedge clk);
      bus.E_MDUop = 4'd5;
      #1 h = bus.E_MUresult;
      bus.E_MDUop = 4'd6;
      #1 l = bus.E_MUresult;
      bus.E_MDUop = 4'd0;
      #1 chk("nop_result", bus.E_MUresult, 0);
   endtask
   task automatic check_hl(input string tag);
      logic [31:0] h, l;
      read_hl(h, l);
      chk({tag, "_hi"}, h, m_hi);
      chk({tag, "_lo"}, l, m_lo);
   endtask
   task automatic expect_hl(input string tag, input logic [31:0] eh, input logic [31:0] el);
      logic [31:0] h, l;
      read_hl(h, l);
      chk({tag, "_hi"}, h, eh);
      chk({tag, "_lo"}, l, el);
   endtask
   // Issues one op; while busy it also tries an MTLO (must be ignored) and pulses Req (must not abort).
   task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic rq);
      bit es, wr;
      logic [63:0] res;
      int n;
      @(negedge clk);
      bus.E_MDUop = op;
      bus.E_A = a;
      bus.E_B = b;
      bus.Req = rq;
      es = starts(op) && !rq;
      #1 chk({tag, "_start"}, bus.E_Start, es);
      model_calc(op, a, b, res, wr);
      @(posedge clk);
      #1;
      if (!rq && op == 4'd7) m_hi = a;
      if (!rq && op == 4'd8) m_lo = a;
      bus.E_MDUop = 4'd0;
      bus.Req = 1'b0;
      n = 0;
      while (bus.E_Busy && n < 100) begin
         bus.E_MDUop = n == 2 ? 4'd8 : 4'd0;
         bus.E_A = $urandom;
         bus.Req = n == 3;
         if (n == 2) #1 chk({tag, "_start_busy"}, bus.E_Start, 0);
         @(posedge clk);
         #1 n++;
      end
      bus.E_MDUop = 4'd0;
      bus.Req = 1'b0;
      chk({tag, "_busy_cycles"}, n, es ? (op inside {4'd3, 4'd4} ? DIV_N : MULT_N) : 0);
      if (es && wr) {m_hi, m_lo} = res;
      check_hl(tag);
   endtask
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
   initial begin
      logic [3:0] ops [15] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd0,
                               4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd15};
      logic [3:0] op;
      logic [31:0] a, b;
      bus.Req = 1'b0;
      bus.E_MDUop = 4'd0;
      bus.E_A = '0;
      bus.E_B = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      chk("reset_busy", bus.E_Busy, 0);
      chk("reset_start", bus.E_Start, 0);
      expect_hl("reset", 32'd0, 32'd0);
      do_op("mult", 4'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
      expect_hl("mult_k", 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      do_op("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
      expect_hl("multu_k", 32'h0000_0001, 32'hFFFF_FFFE);
      do_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
      expect_hl("div_k", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      do_op("mthi", 4'd7, 32'h1234, 32'd0, 1'b0);
      do_op("mtlo", 4'd8, 32'h1234, 32'd0, 1'b0);
      do_op("divu0", 4'd4, 32'd7, 32'd0, 1'b0);
      expect_hl("divu0_k", 32'h1234, 32'h1234);
      do_op("mult_req", 4'd1, 32'd9, 32'd9, 1'b1);
      expect_hl("mult_req_k", 32'h1234, 32'h1234);
      do_op("mthi_req", 4'd7, 32'h5555, 32'd0, 1'b1);
      do_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      expect_hl("div_ovf_k", 32'd0, 32'h8000_0000);
      // reset landing in busy cycle 3 of a MULT must cancel the pending write
      @(negedge clk);
      bus.E_MDUop = 4'd1;
      bus.E_A = 32'd3;
      bus.E_B = 32'd5;
      @(posedge clk);
      #1 bus.E_MDUop = 4'd0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_mid_busy", bus.E_Busy, 0);
      m_hi = '0;
      m_lo = '0;
      repeat (8) @(posedge clk);
      chk("rst_late_busy", bus.E_Busy, 0);
      check_hl("rst_mid");
      do_op("mtlo_dead", 4'd8, 32'hDEAD_BEEF, 32'd0, 1'b0);
      expect_hl("mtlo_dead_k", 32'd0, 32'hDEAD_BEEF);
      if (MADD) begin
         do_op("z_hi", 4'd7, 32'd0, 32'd0, 1'b0);
         do_op("f_lo", 4'd8, 32'hFFFF_FFFF, 32'd0, 1'b0);
         do_op("maddu", 4'd10, 32'd1, 32'd1, 1'b0);
         expect_hl("maddu_k", 32'd1, 32'd0);
         do_op("msub", 4'd11, 32'd1, 32'd1, 1'b0);
         expect_hl("msub_k", 32'd0, 32'hFFFF_FFFF);
      end else begin
         do_op("h55", 4'd7, 32'h55, 32'd0, 1'b0);
         do_op("l55", 4'd8, 32'h55, 32'd0, 1'b0);
         do_op("madd_off", 4'd9, 32'd1, 32'd1, 1'b0);
         expect_hl("madd_off_k", 32'h55, 32'h55);
      end
      for (int i = 0; i < 40; i++) begin
         op = ops[$urandom_range(0, 14)];
         a = $urandom;
         b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 3) == 0) a = {{28{a[31]}}, a[3:0]};
         do_op("rand", op, a, b, $urandom_range(0, 5) == 0);
      end
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
